// File: rtl/aud_pkg.sv
// Shared types for the WM8731 DAC serializer: serializer FSM states and framing modes.
package aud_pkg;

  localparam int unsigned AUD_MODE_W = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } aud_ser_state_t;

  typedef enum logic [AUD_MODE_W-1:0] {
    AUD_MODE_LJ  = 1'b0,
    AUD_MODE_I2S = 1'b1
  } aud_mode_e;

endpackage

// File: rtl/aud_sample_fifo.sv
// Small synchronous FIFO for stereo frames, clocked on the falling edge of the codec bit clock.
// Read data is show-ahead: rd_data_c always presents the oldest entry.
module aud_sample_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_bclk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push   = push && (count != CW'(DEPTH));
  assign do_pop    = pop && (count != CW'(0));
  assign rd_data_c = mem[rd_ptr];
  assign empty_c   = (count == CW'(0));

  always_ff @(negedge i_bclk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/aud_dac_serializer.sv
// Stereo DAC serializer: buffers {left,right} frames and shifts them MSB-first onto DACDAT,
// framed by the codec LR clock. Optional AUD_DAC_UNDERRUN_CNT_EN adds a saturating underrun counter.
module aud_dac_serializer
  import aud_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SLOT_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEFT_LVL   = 1
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun
`ifdef AUD_DAC_UNDERRUN_CNT_EN
  ,
  input  logic              i_cnt_clr,
  output logic [15:0]       o_underrun_cnt
`endif
);

  localparam int unsigned FRAME_W = 2 * DATA_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  aud_ser_state_t    state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shadow_l_q, shadow_l_d;
  logic [DATA_W-1:0] shadow_r_q, shadow_r_d;
  logic [DATA_W-1:0] word;
  logic              dat_d;
  logic              und_d;
  logic              lrc_q;
  logic              lrc_edge;
  logic              is_left;
  logic              pend_bit;
  aud_mode_e         mode_sel;

  logic              push;
  logic              pop;
  logic [FRAME_W-1:0] rd_data_c;
  logic              empty_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_nxt;

  aud_sample_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_bclk    (i_bclk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .wr_data   ({i_left, i_right}),
    .pop       (pop),
    .rd_data_c (rd_data_c),
    .empty_c   (empty_c),
    .count     (fifo_count)
  );

  assign push      = i_valid && o_ready;
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign lrc_edge  = (i_daclrck != lrc_q);
  assign is_left   = (i_daclrck == 1'(LEFT_LVL));
  assign mode_sel  = aud_mode_e'(i_mode);
  // A word cut short by an LRC edge still owes its next bit; I2S places it in the delay slot.
  assign pend_bit  = (state_q == S_SHIFT) && (bit_cnt_q != BIT_W'(DATA_W)) && shreg_q[DATA_W-1];

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    shadow_l_d = shadow_l_q;
    shadow_r_d = shadow_r_q;
    word       = '0;
    dat_d      = 1'b0;
    und_d      = 1'b0;
    pop        = 1'b0;

    if (lrc_edge && i_en) begin
      if (is_left) begin
        if (!empty_c) begin
          pop        = 1'b1;
          shadow_l_d = rd_data_c[FRAME_W-1:DATA_W];
          shadow_r_d = rd_data_c[DATA_W-1:0];
          word       = rd_data_c[FRAME_W-1:DATA_W];
        end else begin
          shadow_l_d = '0;
          shadow_r_d = '0;
          und_d      = 1'b1;
        end
      end else begin
        word = shadow_r_q;
      end
      if (mode_sel == AUD_MODE_I2S) begin
        state_d   = S_DELAY;
        shreg_d   = word;
        bit_cnt_d = '0;
        dat_d     = pend_bit;
      end else begin
        state_d   = S_SHIFT;
        shreg_d   = {word[DATA_W-2:0], 1'b0};
        bit_cnt_d = BIT_W'(1);
        dat_d     = word[DATA_W-1];
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_DELAY: begin
          state_d   = S_SHIFT;
          dat_d     = shreg_q[DATA_W-1];
          shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
          bit_cnt_d = BIT_W'(1);
        end
        S_SHIFT: begin
          if (bit_cnt_q == BIT_W'(DATA_W)) begin
            state_d = ((SLOT_W > DATA_W) && i_en) ? S_PAD : S_IDLE;
          end else begin
            dat_d     = shreg_q[DATA_W-1];
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        S_PAD: begin
          if (!i_en) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Edge detector samples the raw LR clock; it is reloaded from the pin on reset so no false edge follows.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      shadow_l_q   <= '0;
      shadow_r_q   <= '0;
      lrc_q        <= i_daclrck;
      o_aud_dacdat <= 1'b0;
      o_underrun   <= 1'b0;
      o_ready      <= 1'b1;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_l_q   <= shadow_l_d;
      shadow_r_q   <= shadow_r_d;
      lrc_q        <= i_daclrck;
      o_aud_dacdat <= dat_d;
      o_underrun   <= und_d;
      o_ready      <= (count_nxt < CNT_W'(FIFO_DEPTH));
    end
  end

`ifdef AUD_DAC_UNDERRUN_CNT_EN
  logic [15:0] und_cnt_q;

  // Saturating count of underrun pulses; clear takes priority.
  always_ff @(negedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      und_cnt_q <= '0;
    end else if (i_cnt_clr) begin
      und_cnt_q <= '0;
    end else if (und_d && (und_cnt_q != 16'hFFFF)) begin
      und_cnt_q <= und_cnt_q + 16'd1;
    end
  end

  assign o_underrun_cnt = und_cnt_q;
`endif

endmodule
